// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared command/response bytes, error codes and sequencer states
package ps2_kbd_pkg;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_RETRY    = 2'b10;
    localparam logic [1:0] ERR_BAT      = 2'b11;
    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_ACK, S_WAIT_BAT, S_DONE, S_ERR
    } state_t;
endpackage

// File: rtl/ps2_cycle_timer.sv
// ps2_cycle_timer: saturating cycle counter that flags when a runtime limit is reached
module ps2_cycle_timer #(
    parameter int W = 26
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] count;
    // count enabled cycles since the last clear, sticking at all-ones instead of wrapping
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable && count != '1) count <= count + 1'b1;
    assign expired = enable && count >= limit;
endmodule

// File: rtl/ps2_kbd_cmd_sequencer.sv
// ps2_kbd_cmd_sequencer: runs keyboard reset / LED command sequences and filters protocol responses from the key stream
module ps2_kbd_cmd_sequencer
    import ps2_kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 2_500_000,
    parameter int BAT_TIMEOUT = 50_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       init_req,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_data,
    output logic       key_data_en
);
    localparam int TW = $clog2((ACK_TIMEOUT > BAT_TIMEOUT ? ACK_TIMEOUT : BAT_TIMEOUT) + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] ACK_LIM   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] BAT_LIM   = TW'(BAT_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    state_t        state;
    logic          is_init, idx, waiting, tmr_clear, expired, consumed, last_byte;
    logic [2:0]    mask;
    logic [RW-1:0] retry;
    logic [7:0]    cur_byte;

    assign waiting   = state == S_WAIT_ACK || state == S_WAIT_BAT;
    assign tmr_clear = !waiting || (state == S_WAIT_ACK && received_data_en && received_data == RSP_ACK);
    assign cur_byte  = idx ? {5'b0, mask} : (is_init ? CMD_RESET : CMD_SET_LED);
    assign last_byte = is_init || idx;
    assign consumed  = (state == S_WAIT_ACK && (received_data == RSP_ACK || received_data == RSP_RESEND)) ||
                       (state == S_WAIT_BAT && (received_data == RSP_BAT_OK || received_data == RSP_BAT_FAIL));

    ps2_cycle_timer #(.W(TW)) u_timer (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (tmr_clear),
        .enable   (waiting),
        .limit    (state == S_WAIT_BAT ? BAT_LIM : ACK_LIM),
        .expired  (expired)
    );

    // sequence FSM: accept a request, send each byte, handle ACK/RESEND/BAT and timeouts
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            error_code <= 2'b00;
            the_command <= 8'h00;
            send_command <= 1'b0;
            is_init <= 1'b0;
            idx <= 1'b0;
            mask <= 3'b000;
            retry <= '0;
        end else begin
            send_command <= 1'b0;
            done <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE:
                    if (init_req || led_req) begin
                        is_init <= init_req;
                        idx <= 1'b0;
                        mask <= led_mask;
                        retry <= '0;
                        busy <= 1'b1;
                        state <= S_SEND;
                    end
                S_SEND: begin
                    the_command <= cur_byte;
                    send_command <= 1'b1;
                    state <= S_WAIT_SENT;
                end
                S_WAIT_SENT:
                    if (command_was_sent) state <= S_WAIT_ACK;
                    else if (error_communication_timed_out) begin
                        error <= 1'b1;
                        error_code <= ERR_TIMEOUT;
                        state <= S_ERR;
                    end
                S_WAIT_ACK:
                    if (received_data_en) begin
                        if (received_data == RSP_ACK) begin
                            retry <= '0;
                            idx <= 1'b1;
                            done <= last_byte && !is_init;
                            state <= !last_byte ? S_SEND : (is_init ? S_WAIT_BAT : S_DONE);
                        end else if (received_data == RSP_RESEND) begin
                            if (retry < RETRY_MAX) begin
                                retry <= retry + 1'b1;
                                state <= S_SEND;
                            end else begin
                                error <= 1'b1;
                                error_code <= ERR_RETRY;
                                state <= S_ERR;
                            end
                        end
                    end else if (expired) begin
                        error <= 1'b1;
                        error_code <= ERR_TIMEOUT;
                        state <= S_ERR;
                    end
                S_WAIT_BAT:
                    if (received_data_en && received_data == RSP_BAT_OK) begin
                        done <= 1'b1;
                        state <= S_DONE;
                    end else if ((received_data_en && received_data == RSP_BAT_FAIL) || (!received_data_en && expired)) begin
                        error <= 1'b1;
                        error_code <= ERR_BAT;
                        state <= S_ERR;
                    end
                default: begin
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end

    // forward every received byte that the current state does not consume as a response
    always_ff @(posedge CLOCK_50 or posedge reset)
        if (reset) begin
            key_data <= 8'h00;
            key_data_en <= 1'b0;
        end else begin
            key_data_en <= received_data_en && !consumed;
            if (received_data_en && !consumed) key_data <= received_data;
        end
endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// tb_ps2_kbd_cmd_sequencer: table-driven cycle vectors plus directed retry/timeout/reset sequences
module tb_ps2_kbd_cmd_sequencer;
    logic       CLOCK_50 = 1'b0, reset = 1'b1, init_req = 1'b0, led_req = 1'b0;
    logic [2:0] led_mask = 3'b000;
    logic       command_was_sent = 1'b0, error_communication_timed_out = 1'b0, received_data_en = 1'b0;
    logic [7:0] received_data = 8'h00;
    logic       busy, done, error, send_command, key_data_en;
    logic [1:0] error_code;
    logic [7:0] the_command, key_data;
    int n_chk = 0, n_fail = 0;

    typedef struct packed {
        logic       ir, lr;
        logic [2:0] m;
        logic       cws, rde;
        logic [7:0] rd;
        logic       busy, done, err, sc;
        logic [7:0] cmd;
        logic       ken;
        logic [7:0] kd;
    } vec_t;
    vec_t v[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_kbd_cmd_sequencer #(.ACK_TIMEOUT(100), .BAT_TIMEOUT(300), .MAX_RETRY(3)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .init_req(init_req), .led_req(led_req), .led_mask(led_mask),
        .busy(busy), .done(done), .error(error), .error_code(error_code), .the_command(the_command),
        .send_command(send_command), .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out), .received_data(received_data),
        .received_data_en(received_data_en), .key_data(key_data), .key_data_en(key_data_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic rx(input logic [7:0] b);
        received_data = b;
        received_data_en = 1'b1;
        step();
        received_data_en = 1'b0;
    endtask

    task automatic sent_ack;
        command_was_sent = 1'b1;
        step();
        command_was_sent = 1'b0;
    endtask

    task automatic req(input logic init, input logic [2:0] m);
        init_req = init;
        led_req = !init;
        led_mask = m;
        step();
        init_req = 1'b0;
        led_req = 1'b0;
    endtask

    task automatic wait_sc(input logic [7:0] exp, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = send_command;
        end
        chk({name, " send_command"}, seen, 1);
        chk({name, " the_command"}, the_command, exp);
    endtask

    task automatic count_err(input int limit, output int n);
        n = 0;
        while (!error && n < limit) begin
            step();
            n++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        //          ir lr m     cws rde rd     busy done err sc cmd    ken kd
        v.push_back('{1, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 1, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 0, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hAA, 1, 1, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 1, 3'd5, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hED, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 1, 0, 8'h00, 1, 0, 0, 0, 8'hED, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 0, 0, 0, 8'hED, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h05, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 1, 0, 8'h00, 1, 0, 0, 0, 8'h05, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 1, 0, 0, 8'h05, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h05, 0, 8'h00});
        v.push_back('{1, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h05, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 1, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 0, 8'h00});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'h1C, 1, 0, 0, 0, 8'hFF, 1, 8'h1C});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hF0, 1, 0, 0, 0, 8'hFF, 1, 8'hF0});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'h1C, 1, 0, 0, 0, 8'hFF, 1, 8'h1C});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 0, 0, 0, 8'hFF, 0, 8'h1C});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 0, 0, 0, 8'hFF, 1, 8'hFA});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hAA, 1, 1, 0, 0, 8'hFF, 0, 8'hFA});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 8'hFA});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFE, 0, 0, 0, 0, 8'hFF, 1, 8'hFE});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hAA, 0, 0, 0, 0, 8'hFF, 1, 8'hAA});
        v.push_back('{1, 1, 3'd7, 0, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 1, 3'd7, 1, 0, 8'h00, 1, 0, 0, 0, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 1, 0, 0, 0, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hAA, 1, 1, 0, 0, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 0, 3'd0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hFF, 0, 8'hAA});
        v.push_back('{0, 0, 3'd0, 0, 1, 8'hFA, 0, 0, 0, 0, 8'hFF, 1, 8'hFA});

        repeat (3) step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset error_code", error_code, 0);
        chk("reset send_command", send_command, 0);
        chk("reset the_command", the_command, 0);
        chk("reset key_data", key_data, 0);
        chk("reset key_data_en", key_data_en, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < v.size(); i++) begin
            init_req = v[i].ir;
            led_req = v[i].lr;
            led_mask = v[i].m;
            command_was_sent = v[i].cws;
            received_data_en = v[i].rde;
            received_data = v[i].rd;
            step();
            chk($sformatf("v%0d busy", i), busy, v[i].busy);
            chk($sformatf("v%0d done", i), done, v[i].done);
            chk($sformatf("v%0d error", i), error, v[i].err);
            chk($sformatf("v%0d send_command", i), send_command, v[i].sc);
            chk($sformatf("v%0d the_command", i), the_command, v[i].cmd);
            chk($sformatf("v%0d key_data_en", i), key_data_en, v[i].ken);
            chk($sformatf("v%0d key_data", i), key_data, v[i].kd);
        end
        {init_req, led_req, command_was_sent, received_data_en} = 4'b0;
        step();

        req(1'b0, 3'b101);
        wait_sc(8'hED, "retry ok ED");
        sent_ack();
        rx(8'hFA);
        wait_sc(8'h05, "retry ok 05 first");
        for (int i = 0; i < 3; i++) begin
            sent_ack();
            rx(8'hFE);
            chk($sformatf("retry ok FE%0d no error", i), error, 0);
            wait_sc(8'h05, $sformatf("retry ok 05 resend%0d", i));
        end
        sent_ack();
        rx(8'hFA);
        chk("retry ok done", done, 1);
        chk("retry ok error", error, 0);
        step();
        chk("retry ok busy low", busy, 0);

        req(1'b0, 3'b101);
        wait_sc(8'hED, "retry ex ED");
        sent_ack();
        rx(8'hFA);
        wait_sc(8'h05, "retry ex 05 first");
        for (int i = 0; i < 3; i++) begin
            sent_ack();
            rx(8'hFE);
            wait_sc(8'h05, $sformatf("retry ex 05 resend%0d", i));
        end
        sent_ack();
        rx(8'hFE);
        chk("retry ex error", error, 1);
        chk("retry ex error_code", error_code, 2'b10);
        chk("retry ex done", done, 0);
        chk("retry ex busy", busy, 1);
        step();
        chk("retry ex busy low", busy, 0);
        chk("retry ex error pulse", error, 0);
        chk("retry ex code held", error_code, 2'b10);

        req(1'b1, 3'b000);
        wait_sc(8'hFF, "ack to");
        sent_ack();
        count_err(200, n);
        chk("ack timeout cycles", n, 100);
        chk("ack timeout code", error_code, 2'b01);
        step();

        req(1'b1, 3'b000);
        wait_sc(8'hFF, "byte wins");
        sent_ack();
        repeat (99) step();
        chk("byte wins pre error", error, 0);
        rx(8'hFA);
        chk("byte wins no error", error, 0);
        chk("byte wins busy", busy, 1);
        count_err(400, n);
        chk("bat timeout cycles", n, 300);
        chk("bat timeout code", error_code, 2'b11);
        step();

        req(1'b0, 3'b001);
        wait_sc(8'hED, "sent to");
        error_communication_timed_out = 1'b1;
        step();
        error_communication_timed_out = 1'b0;
        chk("sent timeout error", error, 1);
        chk("sent timeout code", error_code, 2'b01);
        step();

        req(1'b1, 3'b000);
        wait_sc(8'hFF, "bat fail");
        sent_ack();
        rx(8'hFA);
        rx(8'hFC);
        chk("bat fail error", error, 1);
        chk("bat fail code", error_code, 2'b11);
        chk("bat fail key_data_en", key_data_en, 0);
        step();

        rx(8'h3A);
        chk("idle fwd key_data", key_data, 8'h3A);
        req(1'b1, 3'b000);
        wait_sc(8'hFF, "rst mid");
        sent_ack();
        rx(8'hFA);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", busy, 0);
        chk("async reset the_command", the_command, 0);
        chk("async reset error_code", error_code, 0);
        chk("async reset key_data", key_data, 0);
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post reset %0d done", i), done, 0);
            chk($sformatf("post reset %0d error", i), error, 0);
            chk($sformatf("post reset %0d busy", i), busy, 0);
        end
        req(1'b0, 3'b010);
        chk("post reset accept busy", busy, 1);
        wait_sc(8'hED, "post reset ED");
        sent_ack();
        rx(8'hFA);
        wait_sc(8'h02, "post reset mask");
        sent_ack();
        rx(8'hFA);
        chk("post reset done", done, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
